// File: rtl/univ_shift_reg.sv
// Universal shift register with multi-step shift sequencing.
// Supports parallel load, clear, logical and arithmetic shifts and rotates.
// A shift of N positions runs as N single-bit steps on consecutive edges,
// bracketed by a start / busy / done handshake. carry_out keeps the last bit
// that left the register.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk_in,
  input  logic             clr_n_in,
  input  logic             start_in,
  input  logic [2:0]       mode_in,
  input  logic [AMT_W-1:0] amount_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_l_in,
  input  logic             serial_r_in,
  output logic [WIDTH-1:0] number_out,
  output logic             carry_out,
  output logic             busy_out,
  output logic             done_out
);

  // Operation encoding seen on mode_in
  typedef enum logic [2:0] {
    MODE_LOAD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_SAR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_NOP   = 3'b111
  } mode_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // One single-bit step of a shift/rotate; returns {carry, number}.
  // Non-shifting modes return the current contents unchanged.
  function automatic logic [WIDTH:0] f_step(
    input mode_e            mode,
    input logic [WIDTH-1:0] num,
    input logic             carry,
    input logic             fill_l,
    input logic             fill_r
  );
    logic [WIDTH:0] res;
    case (mode)
      MODE_SHL: res = {num[WIDTH-1], num[WIDTH-2:0], fill_l};
      MODE_SHR: res = {num[0], fill_r, num[WIDTH-1:1]};
      MODE_SAR: res = {num[0], num[WIDTH-1], num[WIDTH-1:1]};
      MODE_ROL: res = {num[WIDTH-1], num[WIDTH-2:0], num[WIDTH-1]};
      MODE_ROR: res = {num[0], num[0], num[WIDTH-1:1]};
      default:  res = {carry, num};
    endcase
    return res;
  endfunction

  // State and datapath registers
  state_e           r_state;
  mode_e            r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_number;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  // Next-state values
  state_e           w_next_state;
  mode_e            w_next_mode;
  logic [AMT_W-1:0] w_next_cnt;
  logic [WIDTH-1:0] w_next_number;
  logic             w_next_carry;
  logic [WIDTH:0]   w_step;
  logic             w_immediate;
  mode_e            w_req_mode;

  assign w_req_mode = mode_e'(mode_in);

  // Requests that complete on the sampling edge itself: load/clear/nop or a zero-length shift
  assign w_immediate = (w_req_mode == MODE_LOAD)  ||
                       (w_req_mode == MODE_CLEAR) ||
                       (w_req_mode == MODE_NOP)   ||
                       (amount_in == {AMT_W{1'b0}});

  // Single-bit step of the latched operation, used in SHIFT
  assign w_step = f_step(r_mode, r_number, r_carry, serial_l_in, serial_r_in);

  // Next-state and datapath decode for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    w_next_state  = r_state;
    w_next_mode   = r_mode;
    w_next_cnt    = r_cnt;
    w_next_number = r_number;
    w_next_carry  = r_carry;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          if (w_immediate) begin
            case (w_req_mode)
              MODE_LOAD: begin
                w_next_number = data_in;
                w_next_carry  = 1'b0;
              end
              MODE_CLEAR: begin
                w_next_number = {WIDTH{1'b0}};
                w_next_carry  = 1'b0;
              end
              default: begin
                w_next_number = r_number;
                w_next_carry  = r_carry;
              end
            endcase
            w_next_state = ST_DONE;
          end else begin
            w_next_mode  = w_req_mode;
            w_next_cnt   = amount_in;
            w_next_state = ST_SHIFT;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_next_carry  = w_step[WIDTH];
        w_next_number = w_step[WIDTH-1:0];
        w_next_cnt    = r_cnt - {{(AMT_W-1){1'b0}}, 1'b1};
        if (r_cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // start_in is deliberately ignored here
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Register update; clr_n_in aborts everything immediately
  always_ff @(posedge clk_in or negedge clr_n_in) begin
    if (!clr_n_in) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_NOP;
      r_cnt    <= {AMT_W{1'b0}};
      r_number <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_mode   <= w_next_mode;
      r_cnt    <= w_next_cnt;
      r_number <= w_next_number;
      r_carry  <= w_next_carry;
      r_busy   <= (w_next_state != ST_IDLE);
      r_done   <= (w_next_state == ST_DONE);
    end
  end

  assign number_out = r_number;
  assign carry_out  = r_carry;
  assign busy_out   = r_busy;
  assign done_out   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random
// operations checked against a closed-form arithmetic model.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int A = 4;

  localparam logic [2:0] M_LOAD  = 3'd0;
  localparam logic [2:0] M_SHL   = 3'd1;
  localparam logic [2:0] M_SHR   = 3'd2;
  localparam logic [2:0] M_SAR   = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_ROR   = 3'd5;
  localparam logic [2:0] M_CLEAR = 3'd6;
  localparam logic [2:0] M_NOP   = 3'd7;

  logic         clk_in = 1'b0;
  logic         clr_n_in;
  logic         start_in;
  logic [2:0]   mode_in;
  logic [A-1:0] amount_in;
  logic [W-1:0] data_in;
  logic         serial_l_in;
  logic         serial_r_in;
  logic [W-1:0] number_out;
  logic         carry_out;
  logic         busy_out;
  logic         done_out;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_num;
  logic         m_carry;

  univ_shift_reg #(.WIDTH(W), .AMT_W(A)) dut (
    .clk_in      (clk_in),
    .clr_n_in    (clr_n_in),
    .start_in    (start_in),
    .mode_in     (mode_in),
    .amount_in   (amount_in),
    .data_in     (data_in),
    .serial_l_in (serial_l_in),
    .serial_r_in (serial_r_in),
    .number_out  (number_out),
    .carry_out   (carry_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Whole-operation result computed from the extended-vector view of a shift
  task automatic model_apply(input logic [2:0] mode, input int n, input logic [W-1:0] data,
                             input logic sl, input logic sr);
    int v;
    int k;
    int m;
    int fill;
    m = int'(m_num);
    fill = (1 << n) - 1;
    case (mode)
      M_LOAD:  begin m_num = data; m_carry = 1'b0; end
      M_CLEAR: begin m_num = '0;   m_carry = 1'b0; end
      M_SHL: if (n > 0) begin
        v = (m << n) | (sl ? fill : 0);
        m_num = v[W-1:0]; m_carry = v[W];
      end
      M_SHR, M_SAR: if (n > 0) begin
        logic f;
        f = (mode == M_SAR) ? m_num[W-1] : sr;
        v = m | (f ? (fill << W) : 0);
        m_carry = v[n-1];
        v = v >> n;
        m_num = v[W-1:0];
      end
      M_ROL: if (n > 0) begin
        k = n % W;
        v = (m << k) | (m >> (W - k));
        m_num = v[W-1:0]; m_carry = m_num[0];
      end
      M_ROR: if (n > 0) begin
        k = n % W;
        v = (m >> k) | (m << (W - k));
        m_num = v[W-1:0]; m_carry = m_num[W-1];
      end
      default: ;
    endcase
  endtask

  // Issue one operation and check busy/done timing and the final result.
  // inject=1 pulses a LOAD request during the busy window, which must be ignored.
  task automatic run_op(input logic [2:0] mode, input logic [A-1:0] amt, input logic [W-1:0] data,
                        input logic sl, input logic sr, input bit inject, input string tag);
    int steps;
    bit imm;
    imm = (mode == M_LOAD) || (mode == M_CLEAR) || (mode == M_NOP) || (amt == '0);
    steps = imm ? 0 : int'(amt);
    model_apply(mode, int'(amt), data, sl, sr);
    @(negedge clk_in);
    start_in = 1'b1; mode_in = mode; amount_in = amt; data_in = data;
    serial_l_in = sl; serial_r_in = sr;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    mode_in = 3'($urandom); amount_in = A'($urandom); data_in = W'($urandom);
    for (int c = 0; c < steps; c++) begin
      @(negedge clk_in);
      checks++;
      if (busy_out !== 1'b1 || done_out !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done step %0d: got busy=%b done=%b, want busy=1 done=0", tag, c, busy_out, done_out);
      end
      if (inject && c == 0) begin
        start_in = 1'b1; mode_in = M_LOAD; data_in = W'($urandom);
      end
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
    end
    @(negedge clk_in);
    checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL %s done pulse: got busy=%b done=%b, want busy=1 done=1", tag, busy_out, done_out);
    end
    checks++;
    if (number_out !== m_num || carry_out !== m_carry) begin
      errors++;
      $display("FAIL %s result: got number=%h carry=%b, want number=%h carry=%b", tag, number_out, carry_out, m_num, m_carry);
    end
    if (inject) begin
      start_in = 1'b1; mode_in = M_CLEAR;
    end
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (done_out !== 1'b0 || busy_out !== 1'b0 || number_out !== m_num) begin
      errors++;
      $display("FAIL %s after done: got busy=%b done=%b number=%h, want busy=0 done=0 number=%h",
               tag, busy_out, done_out, number_out, m_num);
    end
  endtask

  task automatic test_reset;
    clr_n_in = 1'b0; start_in = 1'b0; mode_in = M_NOP; amount_in = '0;
    data_in = '0; serial_l_in = 1'b0; serial_r_in = 1'b0;
    m_num = '0; m_carry = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (number_out !== 8'h00 || carry_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: got number=%h carry=%b busy=%b done=%b, want all zero", number_out, carry_out, busy_out, done_out);
    end
    @(negedge clk_in);
    clr_n_in = 1'b1;
  endtask

  task automatic test_directed;
    run_op(M_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
    run_op(M_LOAD, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, "load_81");
    run_op(M_SHL,  4'd3, 8'h00, 1'b1, 1'b0, 1'b0, "shl3");
    checks++;
    if (number_out !== 8'h0F || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL shl3_const: got %h/%b, want 0f/0", number_out, carry_out);
    end
    run_op(M_LOAD, 4'd0, 8'h90, 1'b0, 1'b0, 1'b0, "load_90");
    run_op(M_SAR,  4'd2, 8'h00, 1'b0, 1'b0, 1'b0, "sar2");
    checks++;
    if (number_out !== 8'hE4 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL sar2_const: got %h/%b, want e4/0", number_out, carry_out);
    end
    run_op(M_LOAD, 4'd0, 8'h03, 1'b0, 1'b0, 1'b0, "load_03");
    run_op(M_SHR,  4'd1, 8'h00, 1'b0, 1'b0, 1'b0, "shr1");
    checks++;
    if (number_out !== 8'h01 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL shr1_const: got %h/%b, want 01/1", number_out, carry_out);
    end
    run_op(M_LOAD, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, "load_81b");
    run_op(M_ROL,  4'd9, 8'h00, 1'b0, 1'b0, 1'b0, "rol9");
    checks++;
    if (number_out !== 8'h03 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL rol9_const: got %h/%b, want 03/1", number_out, carry_out);
    end
  endtask

  task automatic test_busy_ignore;
    run_op(M_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, "load_3c");
    run_op(M_SHR,  4'd4, 8'h00, 1'b1, 1'b1, 1'b1, "shr4_inject");
    run_op(M_SHL,  4'd0, 8'h00, 1'b1, 1'b1, 1'b0, "shl0");
    run_op(M_ROR,  4'd15, 8'h00, 1'b0, 1'b0, 1'b1, "ror15_inject");
    run_op(M_SHL,  4'd12, 8'h00, 1'b1, 1'b0, 1'b0, "shl12_fill");
  endtask

  task automatic test_reset_mid;
    run_op(M_LOAD, 4'd0, 8'hC3, 1'b0, 1'b0, 1'b0, "load_c3");
    @(negedge clk_in);
    start_in = 1'b1; mode_in = M_ROR; amount_in = 4'd5;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    clr_n_in = 1'b0;
    #1;
    m_num = '0; m_carry = 1'b0;
    checks++;
    if (number_out !== 8'h00 || busy_out !== 1'b0 || done_out !== 1'b0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got number=%h carry=%b busy=%b done=%b, want all zero",
               number_out, carry_out, busy_out, done_out);
    end
    @(negedge clk_in);
    clr_n_in = 1'b1;
    run_op(M_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0, "post_reset_load");
    run_op(M_ROR,  4'd5, 8'h00, 1'b0, 1'b0, 1'b0, "post_reset_ror5");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom), A'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
